// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width, FSM state encoding
// and the iteration-counter width helper.
package div_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// Combinational W-bit trial subtract a - b as a ripple chain of fag cells.
// borrow is high when b > a.
module div_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0]   carry;
    logic [W-1:0] b_inv;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    // a + ~b + 1; the final carry-out is the inverse of the borrow
    for (genvar gi = 0; gi < W; gi++) begin : g_chain
        fag u_fag (
            .a  (a[gi]),
            .b  (b_inv[gi]),
            .ci (carry[gi]),
            .s  (diff[gi]),
            .co (carry[gi+1])
        );
    end

    assign borrow = ~carry[W];

endmodule

// File: rtl/fag.sv
// One-bit full adder cell used to build the ripple subtract chain.
module fag (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, 2*DW / DW -> DW quotient + DW remainder.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIX sign-correction state).
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div0,
    output logic            ovf
);

    localparam int CW = cnt_width(DW);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   r_q, r_d;
    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic            wdiv0_q, wdiv0_d;
    logic            wovf_q, wovf_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;

    logic [2*DW-1:0] dd_mag;
    logic [DW-1:0]   dv_mag;
    logic [DW:0]     step_a;
    logic [DW:0]     step_b;
    logic [DW:0]     step_diff;
    logic            step_borrow;
    logic            trial_ok;

`ifdef DIV_SIGNED_EN
    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MAX = {1'b1, {(DW-1){1'b0}}};

    logic neg_q, neg_d;
    logic sdd_q, sdd_d;

    assign dd_mag = dividend[2*DW-1] ? -dividend : dividend;
    assign dv_mag = divisor[DW-1]    ? -divisor  : divisor;
`else
    assign dd_mag = dividend;
    assign dv_mag = divisor;
`endif

    assign step_a = {r_q, lo_q[DW-1]};
    assign step_b = {1'b0, dvs_q};

    div_step #(.W(DW + 1)) u_step (
        .a      (step_a),
        .b      (step_b),
        .diff   (step_diff),
        .borrow (step_borrow)
    );

    // A successful trial always leaves a difference below the divisor, so bit DW is clear
    assign trial_ok = ~step_borrow & ~step_diff[DW];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        wdiv0_d     = wdiv0_q;
        wovf_d      = wovf_q;
        out_valid_d = out_valid_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
`ifdef DIV_SIGNED_EN
        neg_d       = neg_q;
        sdd_d       = sdd_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div0_d  = 1'b0;
                    ovf_d   = 1'b0;
                    dvs_d   = dv_mag;
                    wdiv0_d = 1'b0;
                    wovf_d  = 1'b0;
`ifdef DIV_SIGNED_EN
                    neg_d   = dividend[2*DW-1] ^ divisor[DW-1];
                    sdd_d   = dividend[2*DW-1];
`endif
                    if (divisor == '0) begin
                        state_d = DONE;
                        wdiv0_d = 1'b1;
                        q_d     = '1;
                        r_d     = dividend[DW-1:0];
                    end else if (dd_mag[2*DW-1:DW] >= dv_mag) begin
                        state_d = DONE;
                        wovf_d  = 1'b1;
                        q_d     = '1;
                        r_d     = '0;
                    end else begin
                        state_d = CALC;
                        r_d     = dd_mag[2*DW-1:DW];
                        lo_d    = dd_mag[DW-1:0];
                        q_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                r_d   = trial_ok ? step_diff[DW-1:0] : step_a[DW-1:0];
                q_d   = {q_q[DW-2:0], trial_ok};
                lo_d  = {lo_q[DW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            FIX: begin
                state_d = DONE;
                if (neg_q ? (q_q > NEG_MAX) : (q_q > POS_MAX)) begin
                    wovf_d = 1'b1;
                    q_d    = '1;
                    r_d    = '0;
                end else begin
                    q_d = neg_q ? -q_q : q_q;
                    r_d = sdd_q ? -r_q : r_q;
                end
            end
`endif
            DONE: begin
                // First DONE cycle publishes the result; later cycles wait for the consumer
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    quo_d       = q_q;
                    rem_d       = r_q;
                    div0_d      = wdiv0_q;
                    ovf_d       = wovf_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            wdiv0_q     <= 1'b0;
            wovf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            sdd_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            wdiv0_q     <= wdiv0_d;
            wovf_q      <= wovf_d;
            out_valid_q <= out_valid_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
`ifdef DIV_SIGNED_EN
            neg_q       <= neg_d;
            sdd_q       <= sdd_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div0      = div0_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider (unsigned build, or signed with DIV_SIGNED_EN).
module tb_seq_divider;

    localparam int DW = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT_N = DW + 2;
`else
    localparam int LAT_N = DW + 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [2*DW-1:0] dividend = '0;
    logic [DW-1:0]   divisor = '0;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div0;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0),
        .ovf       (ovf)
    );

    task automatic issue(input logic [2*DW-1:0] dd, input logic [DW-1:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic retire;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({in_ready, out_valid, div0, ovf} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b div0=%b ovf=%b want 1 0 0 0", in_ready, out_valid, div0, ovf);
        end
        checks++;
        if ({quotient, remainder} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got q=%h r=%h want 00 00", quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_normal;
        int n;
        issue(16'd1000, 8'd7);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL normal_busy got in_ready=%b want 0", in_ready);
        end
        wait_valid(n);
        checks++;
        if (n != LAT_N) begin
            errors++;
            $display("FAIL normal_latency got %0d want %0d", n, LAT_N);
        end
        checks++;
        if ({quotient, remainder, div0, ovf} !== {8'd142, 8'd6, 2'b00}) begin
            errors++;
            $display("FAIL normal_result got q=%0d r=%0d div0=%b ovf=%b want 142 6 0 0", quotient, remainder, div0, ovf);
        end
        retire();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL normal_retire got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        $display("txn 1000/7 q=%0d r=%0d lat=%0d", quotient, remainder, n);
    endtask

    task automatic test_ovf;
        int n;
        issue(16'hFFFF, 8'hFF);
        wait_valid(n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL ovf_latency got %0d want 1", n);
        end
        checks++;
        if ({quotient, remainder, div0, ovf} !== {8'hFF, 8'h00, 2'b01}) begin
            errors++;
            $display("FAIL ovf_result got q=%h r=%h div0=%b ovf=%b want ff 00 0 1", quotient, remainder, div0, ovf);
        end
        retire();
        $display("txn ffff/ff q=%h r=%h ovf=%b lat=%0d", quotient, remainder, ovf, n);
    endtask

    task automatic test_div0;
        int n;
        issue(16'd1234, 8'd0);
        wait_valid(n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL div0_latency got %0d want 1", n);
        end
        checks++;
        if ({quotient, remainder, div0, ovf} !== {8'hFF, 8'hD2, 2'b10}) begin
            errors++;
            $display("FAIL div0_result got q=%h r=%h div0=%b ovf=%b want ff d2 1 0", quotient, remainder, div0, ovf);
        end
        retire();
        $display("txn 1234/0 q=%h r=%h div0=%b lat=%0d", quotient, remainder, div0, n);
    endtask

    task automatic test_hold;
        int n;
        issue(16'd40000, 8'd200);
        wait_valid(n);
        checks++;
        if (n != LAT_N || {quotient, remainder, div0, ovf} !== {8'd200, 8'd0, 2'b00}) begin
            errors++;
            $display("FAIL hold_result got q=%0d r=%0d flags=%b%b lat=%0d want 200 0 00 lat %0d", quotient, remainder, div0, ovf, n, LAT_N);
        end
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, quotient, remainder} !== {2'b10, 8'd200, 8'd0}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got vld=%b rdy=%b q=%0d r=%0d want 1 0 200 0", i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid = 1'b0;
        retire();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_no_phantom got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        $display("txn 40000/200 q=%0d r=%0d held 5 cycles", quotient, remainder);
    endtask

    task automatic test_abort;
        int n;
        issue(16'd1000, 8'd7);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, div0, ovf, quotient, remainder} !== {4'b0100, 16'h0000}) begin
            errors++;
            $display("FAIL abort_reset got vld=%b rdy=%b div0=%b ovf=%b q=%h r=%h want 0 1 0 0 00 00", out_valid, in_ready, div0, ovf, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result got vld=%b want 0", out_valid);
        end
        issue(16'd255, 8'd16);
        wait_valid(n);
        checks++;
        if (n != LAT_N || {quotient, remainder, div0, ovf} !== {8'd15, 8'd15, 2'b00}) begin
            errors++;
            $display("FAIL abort_next got q=%0d r=%0d flags=%b%b lat=%0d want 15 15 00 lat %0d", quotient, remainder, div0, ovf, n, LAT_N);
        end
        retire();
        $display("txn abort then 255/16 q=%0d r=%0d", quotient, remainder);
    endtask

`ifndef DIV_SIGNED_EN
    task automatic test_random_unsigned;
        int n;
        int dv;
        int dd;
        int exp_lat;
        logic [17:0] want;
        for (int i = 0; i < 300; i++) begin
            dv = $urandom_range(1, 255);
            if (i % 16 == 5) begin
                dd = $urandom_range(0, 65535);
                dv = 0;
                want = {8'hFF, 8'(dd), 2'b10};
                exp_lat = 1;
            end else if (i % 8 == 3) begin
                dd = (dv << 8) + $urandom_range(0, 255);
                if (dd > 65535) dd = 65535;
                want = {8'hFF, 8'h00, 2'b01};
                exp_lat = 1;
            end else begin
                dd = $urandom_range(0, dv * 256 - 1);
                want = {8'(dd / dv), 8'(dd % dv), 2'b00};
                exp_lat = LAT_N;
            end
            issue(16'(dd), 8'(dv));
            wait_valid(n);
            checks++;
            if (n != exp_lat || {quotient, remainder, div0, ovf} !== want) begin
                errors++;
                $display("FAIL rand_u %0d/%0d got q=%0d r=%0d flags=%b%b lat=%0d want q=%0d r=%0d flags=%b lat=%0d",
                         dd, dv, quotient, remainder, div0, ovf, n, want[17:10], want[9:2], want[1:0], exp_lat);
            end
            retire();
            $display("txn rand %0d/%0d q=%0d r=%0d flags=%b%b", dd, dv, quotient, remainder, div0, ovf);
        end
    endtask
`else
    task automatic test_signed;
        int n;
        issue(16'hFF9C, 8'd7);
        wait_valid(n);
        checks++;
        if (n != LAT_N || {quotient, remainder, div0, ovf} !== {8'hF2, 8'hFE, 2'b00}) begin
            errors++;
            $display("FAIL signed_basic got q=%h r=%h flags=%b%b lat=%0d want f2 fe 00 lat %0d", quotient, remainder, div0, ovf, n, LAT_N);
        end
        retire();
        $display("txn -100/7 q=%0d r=%0d", $signed(quotient), $signed(remainder));
        issue(16'h4000, 8'd1);
        wait_valid(n);
        checks++;
        if (n != 1 || {quotient, remainder, div0, ovf} !== {8'hFF, 8'h00, 2'b01}) begin
            errors++;
            $display("FAIL signed_ovf got q=%h r=%h flags=%b%b lat=%0d want ff 00 01 lat 1", quotient, remainder, div0, ovf, n);
        end
        retire();
        $display("txn 16384/1 ovf=%b", ovf);
    endtask

    task automatic test_random_signed;
        int n;
        int a;
        int b;
        int qe;
        int re;
        int exp_lat;
        logic [17:0] want;
        for (int i = 0; i < 2000; i++) begin
            b = int'($urandom_range(0, 255)) - 128;
            if (b == 0) b = 1;
            a = (int'($urandom_range(0, 255)) - 128) * b + int'($urandom_range(0, 20)) - 10;
            qe = a / b;
            re = a % b;
            if (qe > 127 || qe < -128) begin
                want = {8'hFF, 8'h00, 2'b01};
                exp_lat = -1;
            end else begin
                want = {8'(qe), 8'(re), 2'b00};
                exp_lat = LAT_N;
            end
            issue(16'(a), 8'(b));
            wait_valid(n);
            checks++;
            if ((exp_lat > 0 && n != exp_lat) || n >= 64 || {quotient, remainder, div0, ovf} !== want) begin
                errors++;
                $display("FAIL rand_s %0d/%0d got q=%0d r=%0d flags=%b%b lat=%0d want q=%0d r=%0d flags=%b",
                         a, b, $signed(quotient), $signed(remainder), div0, ovf, n,
                         $signed(want[17:10]), $signed(want[9:2]), want[1:0]);
            end
            retire();
            $display("txn rand %0d/%0d q=%0d r=%0d flags=%b%b", a, b, $signed(quotient), $signed(remainder), div0, ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DIV_SIGNED_EN
        test_div0();
        test_signed();
        test_random_signed();
`else
        test_normal();
        test_ovf();
        test_div0();
        test_hold();
        test_abort();
        test_random_unsigned();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
